// File: rtl/iir_pkg.sv
// Shared definitions for the IIR coefficient loader: FSM state encoding,
// default bank depth and counter width helpers.
package iir_pkg;

    localparam int DEF_NUM_COEFFICIENTS = 13;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_GAP   = 2'd2
    } loader_state_e;

    // A single-entry bank still needs a 1-bit index to stay a legal vector.
    function automatic int idx_width(input int num_coeffs);
        return (num_coeffs > 1) ? $clog2(num_coeffs) : 1;
    endfunction

    function automatic int tmr_width(input int timeout_cycles);
        return $clog2(timeout_cycles + 1);
    endfunction

endpackage

// File: rtl/coeff_shadow_bank.sv
// Shadow coefficient registers behind a Wishbone write slave; writes are
// stalled (ack withheld) while the loader streams the bank out.
module coeff_shadow_bank
    import iir_pkg::*;
#(
    parameter int P_NUM_COEFFICIENTS = DEF_NUM_COEFFICIENTS,
    parameter int P_ADDR_MSB         = 3,
    parameter int P_DATA_MSB         = 15,
    localparam int IDX_W             = idx_width(P_NUM_COEFFICIENTS)
) (
    input  logic              i_clk,
    input  logic              i_reset_sync,
    input  logic              stall,
    input  logic              wr_stb,
    input  logic [P_ADDR_MSB:0] wr_addr,
    input  logic [P_DATA_MSB:0] wr_data,
    output logic              wr_ack,
    input  logic [IDX_W-1:0]  rd_idx,
    output logic [P_DATA_MSB:0] rd_data
);

    localparam int AW = P_ADDR_MSB + 1;

    logic [P_DATA_MSB:0] bank [P_NUM_COEFFICIENTS];
    logic                wr_take;

    // Out-of-range addresses match no entry, so they are acked and dropped.
    assign wr_take = wr_stb && !wr_ack && !stall;

    always_ff @(posedge i_clk) begin
        if (i_reset_sync) begin
            wr_ack <= 1'b0;
            for (int i = 0; i < P_NUM_COEFFICIENTS; i++) begin
                bank[i] <= '0;
            end
        end else begin
            wr_ack <= wr_take;
            for (int i = 0; i < P_NUM_COEFFICIENTS; i++) begin
                if (wr_take && (wr_addr == AW'(i))) begin
                    bank[i] <= wr_data;
                end
            end
        end
    end

    always_comb begin
        rd_data = '0;
        for (int i = 0; i < P_NUM_COEFFICIENTS; i++) begin
            if (rd_idx == IDX_W'(i)) begin
                rd_data = bank[i];
            end
        end
    end

endmodule

// File: rtl/iir_coeff_loader.sv
// Wishbone write master that streams the shadow coefficient bank into the
// IIR filter, one beat per word with a one-cycle gap between beats.
//
// state   | meaning
// S_IDLE  | waiting for start; shadow bank accepts cfg writes
// S_ISSUE | stb high for the current index until ack or timeout
// S_GAP   | stb low for one cycle, index advances
module iir_coeff_loader
    import iir_pkg::*;
#(
    parameter int P_NUM_COEFFICIENTS = DEF_NUM_COEFFICIENTS,
    parameter int P_ADDR_MSB         = 3,
    parameter int P_DATA_MSB         = 15,
    parameter int P_TIMEOUT_CYCLES   = 15
) (
    input  logic                i_clk,
    input  logic                i_reset_sync,
    input  logic                i_cfg_write_stb,
    input  logic [P_ADDR_MSB:0] i_cfg_write_addr,
    input  logic [P_DATA_MSB:0] i_cfg_write_data,
    output logic                o_cfg_write_ack,
    input  logic                i_start,
    output logic                o_busy,
    output logic                o_done,
    output logic                o_error,
    output logic                o_master_write_stb,
    output logic [P_ADDR_MSB:0] o_master_write_addr,
    output logic [P_DATA_MSB:0] o_master_write_data,
    input  logic                i_master_write_ack
);

    localparam int AW    = P_ADDR_MSB + 1;
    localparam int IDX_W = idx_width(P_NUM_COEFFICIENTS);
    localparam int TMR_W = tmr_width(P_TIMEOUT_CYCLES);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(P_NUM_COEFFICIENTS - 1);
    localparam logic [TMR_W-1:0] TMO_LAST = TMR_W'(P_TIMEOUT_CYCLES - 1);

    loader_state_e       state, state_nxt;
    logic [IDX_W-1:0]    index, index_nxt;
    logic [TMR_W-1:0]    timer, timer_nxt;
    logic                done_nxt, error_nxt;
    logic                loading;
    logic [P_DATA_MSB:0] rd_data;

    assign loading = (state != S_IDLE);

    coeff_shadow_bank #(
        .P_NUM_COEFFICIENTS (P_NUM_COEFFICIENTS),
        .P_ADDR_MSB         (P_ADDR_MSB),
        .P_DATA_MSB         (P_DATA_MSB)
    ) u_bank (
        .i_clk        (i_clk),
        .i_reset_sync (i_reset_sync),
        .stall        (loading),
        .wr_stb       (i_cfg_write_stb),
        .wr_addr      (i_cfg_write_addr),
        .wr_data      (i_cfg_write_data),
        .wr_ack       (o_cfg_write_ack),
        .rd_idx       (index),
        .rd_data      (rd_data)
    );

    always_ff @(posedge i_clk) begin
        if (i_reset_sync) begin
            state   <= S_IDLE;
            index   <= '0;
            timer   <= '0;
            o_done  <= 1'b0;
            o_error <= 1'b0;
        end else begin
            state   <= state_nxt;
            index   <= index_nxt;
            timer   <= timer_nxt;
            o_done  <= done_nxt;
            o_error <= error_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        index_nxt = index;
        timer_nxt = timer;
        done_nxt  = 1'b0;
        error_nxt = o_error;
        case (state)
            S_IDLE: begin
                if (i_start) begin
                    state_nxt = S_ISSUE;
                    index_nxt = '0;
                    timer_nxt = '0;
                    error_nxt = 1'b0;
                end
            end
            S_ISSUE: begin
                // An ack on the last allowed cycle still counts as success.
                if (i_master_write_ack) begin
                    timer_nxt = '0;
                    if (index == LAST_IDX) begin
                        state_nxt = S_IDLE;
                        done_nxt  = 1'b1;
                    end else begin
                        state_nxt = S_GAP;
                    end
                end else if (timer == TMO_LAST) begin
                    state_nxt = S_IDLE;
                    timer_nxt = '0;
                    error_nxt = 1'b1;
                end else begin
                    timer_nxt = timer + 1'b1;
                end
            end
            S_GAP: begin
                index_nxt = index + 1'b1;
                state_nxt = S_ISSUE;
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    assign o_busy              = loading;
    assign o_master_write_stb  = (state == S_ISSUE);
    assign o_master_write_addr = AW'(index);
    assign o_master_write_data = rd_data;

endmodule
